// File: rtl/dac_spi_tx.sv
// Serialises 12-bit DDS samples plus a 2-bit power-down field into 16-bit SPI frames for a DAC.
// Latency: sync_n falls two clk edges after an accept from idle; a frame occupies 33*DIV+GAP+1 cycles.
// Backpressure: a one-entry pending register; sample_ready is low while it holds an unsent sample.
module dac_spi_tx #(
    parameter int DAC_WIDTH = 12,
    parameter int DIV       = 2,
    parameter int GAP       = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DAC_WIDTH-1:0] sample_in,
    input  logic [1:0]           pd_mode,
    input  logic                 sample_valid,
    output logic                 sample_ready,
    output logic                 dac_sclk,
    output logic                 dac_sync_n,
    output logic                 dac_din,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int HW = $clog2(DIV + 1);
    localparam int GW = $clog2(GAP + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(DIV - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(GAP - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [HW-1:0]          hcnt_q, hcnt_d;
    logic [GW-1:0]          gcnt_q, gcnt_d;
    logic [3:0]             bcnt_q, bcnt_d;
    logic [15:0]            shreg_q, shreg_d;
    logic                   pend_full_q, pend_full_d;
    logic [DAC_WIDTH+1:0]   pend_dat_q, pend_dat_d;
    logic                   sclk_q, sclk_d;
    logic                   sync_n_q, sync_n_d;
    logic                   din_q, din_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   accept;
    logic [15:0]            frame;

    assign sample_ready = ~pend_full_q & ~rst;
    assign accept       = sample_valid & sample_ready;
    assign frame        = {2'b00, pend_dat_q};

    assign dac_sclk   = sclk_q;
    assign dac_sync_n = sync_n_q;
    assign dac_din    = din_q;
    assign busy       = busy_q;
    assign frame_done = done_q;

    always_comb begin
        state_d     = state_q;
        hcnt_d      = hcnt_q;
        gcnt_d      = gcnt_q;
        bcnt_d      = bcnt_q;
        shreg_d     = shreg_q;
        pend_full_d = pend_full_q;
        pend_dat_d  = pend_dat_q;
        sclk_d      = sclk_q;
        sync_n_d    = sync_n_q;
        din_d       = din_q;
        done_d      = 1'b0;

        // Accept and consume are exclusive: ready is low whenever pending is full.
        if (accept) begin
            pend_full_d = 1'b1;
            pend_dat_d  = {pd_mode, sample_in};
        end

        case (state_q)
            IDLE: begin
                sync_n_d = 1'b1;
                sclk_d   = 1'b1;
                din_d    = 1'b0;
                if (pend_full_q) begin
                    pend_full_d = 1'b0;
                    din_d       = frame[15];
                    shreg_d     = {frame[14:0], 1'b0};
                    sync_n_d    = 1'b0;
                    hcnt_d      = '0;
                    state_d     = SETUP;
                end
            end
            SETUP: begin
                if (hcnt_q == HALF_LAST) begin
                    hcnt_d  = '0;
                    bcnt_d  = 4'd0;
                    sclk_d  = 1'b0;
                    state_d = SHIFT;
                end else begin
                    hcnt_d = hcnt_q + HW'(1);
                end
            end
            SHIFT: begin
                if (hcnt_q != HALF_LAST) begin
                    hcnt_d = hcnt_q + HW'(1);
                end else begin
                    hcnt_d = '0;
                    if (!sclk_q) begin
                        // Next bit is presented on the rising edge, far from the DAC's falling-edge sample.
                        sclk_d  = 1'b1;
                        din_d   = shreg_q[15];
                        shreg_d = {shreg_q[14:0], 1'b0};
                    end else if (bcnt_q == 4'd15) begin
                        sync_n_d = 1'b1;
                        din_d    = 1'b0;
                        gcnt_d   = '0;
                        done_d   = 1'b1;
                        state_d  = HOLD;
                    end else begin
                        bcnt_d = bcnt_q + 4'd1;
                        sclk_d = 1'b0;
                    end
                end
            end
            HOLD: begin
                if (gcnt_q == GAP_LAST) begin
                    gcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    gcnt_d = gcnt_q + GW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            hcnt_q      <= '0;
            gcnt_q      <= '0;
            bcnt_q      <= '0;
            shreg_q     <= '0;
            pend_full_q <= 1'b0;
            pend_dat_q  <= '0;
            sclk_q      <= 1'b1;
            sync_n_q    <= 1'b1;
            din_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            gcnt_q      <= gcnt_d;
            bcnt_q      <= bcnt_d;
            shreg_q     <= shreg_d;
            pend_full_q <= pend_full_d;
            pend_dat_q  <= pend_dat_d;
            sclk_q      <= sclk_d;
            sync_n_q    <= sync_n_d;
            din_q       <= din_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: instance 0 uses DIV=2/GAP=2, instance 1 uses DIV=1/GAP=1.
// A per-instance DAC model captures din on sclk falling edges while sync_n is low.
module tb_dac_spi_tx;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] s_dat [2];
    logic [1:0]  s_pd  [2];
    logic [1:0]  s_vld, s_rdy, d_sclk, d_sync, d_din, d_busy, d_fd;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;

    dac_spi_tx #(.DAC_WIDTH(12), .DIV(2), .GAP(2)) u_dut0 (
        .clk(clk), .rst(rst), .sample_in(s_dat[0]), .pd_mode(s_pd[0]),
        .sample_valid(s_vld[0]), .sample_ready(s_rdy[0]), .dac_sclk(d_sclk[0]),
        .dac_sync_n(d_sync[0]), .dac_din(d_din[0]), .busy(d_busy[0]), .frame_done(d_fd[0])
    );

    dac_spi_tx #(.DAC_WIDTH(12), .DIV(1), .GAP(1)) u_dut1 (
        .clk(clk), .rst(rst), .sample_in(s_dat[1]), .pd_mode(s_pd[1]),
        .sample_valid(s_vld[1]), .sample_ready(s_rdy[1]), .dac_sclk(d_sclk[1]),
        .dac_sync_n(d_sync[1]), .dac_din(d_din[1]), .busy(d_busy[1]), .frame_done(d_fd[1])
    );

    // DAC model state, one slot per instance
    logic [15:0] word_log [2][16];
    int          low_log  [2][16];
    int          fall_t   [2][16];
    int          nfall [2] = '{0, 0};
    int          ncomp [2] = '{0, 0};
    int          npart [2] = '{0, 0};
    int          fd_cnt [2] = '{0, 0};
    int          fd_miss [2] = '{0, 0};
    int          din_err [2] = '{0, 0};
    int          busy_gap [2] = '{0, 0};
    int          low_cnt [2] = '{0, 0};
    int          bits [2] = '{0, 0};
    int          last_low [2] = '{0, 0};
    logic [15:0] sh [2];
    logic        p_sync [2] = '{1'b1, 1'b1};
    logic        p_sclk [2] = '{1'b1, 1'b1};
    logic        p_busy [2] = '{1'b0, 1'b0};
    logic        held [2];

    always @(negedge clk) begin
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (p_sync[d] === 1'b1 && d_sync[d] === 1'b0) begin
                if (nfall[d] < 16) fall_t[d][nfall[d]] = cyc;
                nfall[d]++;
                low_cnt[d] = 0;
                bits[d] = 0;
                sh[d] = '0;
            end
            if (d_sync[d] === 1'b0) begin
                low_cnt[d]++;
                last_low[d] = cyc;
                if (p_sclk[d] === 1'b1 && d_sclk[d] === 1'b0) begin
                    sh[d] = {sh[d][14:0], d_din[d]};
                    bits[d]++;
                    held[d] = d_din[d];
                end else if (d_sclk[d] === 1'b0 && d_din[d] !== held[d]) begin
                    din_err[d]++;
                end
            end
            if (p_sync[d] === 1'b0 && d_sync[d] === 1'b1) begin
                if (bits[d] == 16) begin
                    if (ncomp[d] < 16) begin
                        word_log[d][ncomp[d]] = sh[d];
                        low_log[d][ncomp[d]]  = low_cnt[d];
                    end
                    ncomp[d]++;
                    if (d_fd[d] !== 1'b1) fd_miss[d]++;
                end else begin
                    npart[d]++;
                end
            end
            if (d_fd[d] === 1'b1) fd_cnt[d]++;
            if (p_busy[d] === 1'b1 && d_busy[d] === 1'b0) busy_gap[d] = cyc - last_low[d];
            p_sync[d] = d_sync[d];
            p_sclk[d] = d_sclk[d];
            p_busy[d] = d_busy[d];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge just after the accepting clk edge.
    task automatic send(input int d, input logic [11:0] v, input logic [1:0] pd,
                        input bit keep, input bit chk_drop);
        int n = 0;
        s_dat[d] = v;
        s_pd[d]  = pd;
        s_vld[d] = 1'b1;
        while (s_rdy[d] !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("send_timeout", 32'(n < 2000), 32'd1);
        @(negedge clk);
        if (chk_drop) chk("rdy_drop", 32'(s_rdy[d]), 32'd0);
        if (!keep) s_vld[d] = 1'b0;
    endtask

    task automatic wait_done(input int d, input int n_req);
        int n = 0;
        while (ncomp[d] < n_req && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("frame_timeout", 32'(n < 3000), 32'd1);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        s_vld = '0;
        for (int d = 0; d < 2; d++) begin
            s_dat[d] = '0;
            s_pd[d]  = '0;
        end
        repeat (3) @(negedge clk);

        chk("rst_sync_n", 32'(d_sync[0]), 32'd1);
        chk("rst_sclk", 32'(d_sclk[0]), 32'd1);
        chk("rst_din", 32'(d_din[0]), 32'd0);
        chk("rst_busy", 32'(d_busy[0]), 32'd0);
        chk("rst_frame_done", 32'(d_fd[0]), 32'd0);
        chk("rst_ready", 32'(s_rdy[0]), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst0", 32'(s_rdy[0]), 32'd1);
        chk("ready_after_rst1", 32'(s_rdy[1]), 32'd1);

        // Single frame 12'hA5C, pd 00
        send(0, 12'hA5C, 2'b00, 1'b0, 1'b0);
        wait_done(0, 1);
        repeat (5) @(negedge clk);
        chk("frame_a5c", 32'(word_log[0][0]), 32'h0A5C);
        chk("sync_low_len", 32'(low_log[0][0]), 32'd66);
        chk("frame_done_cnt", 32'(fd_cnt[0]), 32'd1);
        chk("frame_done_at_rise", 32'(fd_miss[0]), 32'd0);
        chk("busy_fall_gap", 32'(busy_gap[0]), 32'd3);

        // Valid held high across four samples
        send(0, 12'd0, 2'b00, 1'b1, 1'b1);
        send(0, 12'd1, 2'b00, 1'b1, 1'b1);
        send(0, 12'd2, 2'b00, 1'b1, 1'b1);
        send(0, 12'd3, 2'b00, 1'b0, 1'b1);
        wait_done(0, 5);
        for (int i = 0; i < 4; i++) chk("burst_word", 32'(word_log[0][1+i]), 32'(i));
        for (int i = 1; i < 4; i++) chk("burst_spacing", 32'(fall_t[0][1+i] - fall_t[0][i]), 32'd69);
        repeat (5) @(negedge clk);

        // Full-scale code with pd 11
        send(0, 12'hFFF, 2'b11, 1'b0, 1'b0);
        wait_done(0, 6);
        repeat (5) @(negedge clk);
        chk("frame_fff", 32'(word_log[0][5]), 32'h3FFF);
        chk("din_stable_low", 32'(din_err[0]), 32'd0);
        chk("sync_low_len_fff", 32'(low_log[0][5]), 32'd66);
        chk("frame_done_total", 32'(fd_cnt[0]), 32'd6);

        // Reset at cycle 20 of a frame with a second sample pending
        send(0, 12'h123, 2'b00, 1'b0, 1'b0);
        n = 0;
        while (d_sync[0] !== 1'b0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("abort_start_timeout", 32'(n < 100), 32'd1);
        send(0, 12'h456, 2'b00, 1'b0, 1'b0);
        chk("pending_held", 32'(s_rdy[0]), 32'd0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_sync_n", 32'(d_sync[0]), 32'd1);
        chk("abort_sclk", 32'(d_sclk[0]), 32'd1);
        chk("abort_din", 32'(d_din[0]), 32'd0);
        chk("abort_busy", 32'(d_busy[0]), 32'd0);
        chk("abort_ready", 32'(s_rdy[0]), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("abort_ready_release", 32'(s_rdy[0]), 32'd1);
        repeat (200) @(negedge clk);
        chk("abort_no_restart", 32'(nfall[0]), 32'd7);
        chk("abort_complete_cnt", 32'(ncomp[0]), 32'd6);
        chk("abort_partial_cnt", 32'(npart[0]), 32'd1);
        chk("abort_idle_busy", 32'(d_busy[0]), 32'd0);

        // Valid presented in the cycle the FSM consumes pending
        send(0, 12'h3C3, 2'b01, 1'b1, 1'b1);
        s_dat[0] = 12'h5A5;
        s_pd[0]  = 2'b10;
        chk("consume_cycle_ready", 32'(s_rdy[0]), 32'd0);
        @(negedge clk);
        chk("ready_after_consume", 32'(s_rdy[0]), 32'd1);
        @(negedge clk);
        chk("second_accepted", 32'(s_rdy[0]), 32'd0);
        s_vld[0] = 1'b0;
        wait_done(0, 8);
        chk("order_first", 32'(word_log[0][6]), 32'h13C3);
        chk("order_second", 32'(word_log[0][7]), 32'h25A5);
        chk("order_spacing", 32'(fall_t[0][8] - fall_t[0][7]), 32'd69);

        // DIV=1, GAP=1 instance
        send(1, 12'h000, 2'b00, 1'b1, 1'b1);
        send(1, 12'h800, 2'b00, 1'b0, 1'b1);
        wait_done(1, 2);
        chk("div1_word0", 32'(word_log[1][0]), 32'h0000);
        chk("div1_word1", 32'(word_log[1][1]), 32'h0800);
        chk("div1_low0", 32'(low_log[1][0]), 32'd33);
        chk("div1_low1", 32'(low_log[1][1]), 32'd33);
        chk("div1_spacing", 32'(fall_t[1][1] - fall_t[1][0]), 32'd35);
        chk("div1_din_stable", 32'(din_err[1]), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
